// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a req/ack data-memory port (optional bus timeout via MEM_ACCESS_TIMEOUT_EN)
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_load,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic        adel,
    output logic        ades,
    output logic [31:0] rdata_aligned,
    output logic [2:0]  bhext_op,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;
    logic        misaligned, accept, timeout;
    logic        ld_load, ld_unsigned;
    logic [1:0]  ld_size, ld_lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, rdata_shift;
    logic [2:0]  ext_calc;

    assign misaligned  = op_size[1] ? (op_addr[1:0] != 2'b00) : (op_size[0] & op_addr[0]);
    assign accept      = !reset && state == IDLE && op_valid && !misaligned;
    assign be_calc     = op_size[1] ? 4'b1111 : op_size[0] ? (4'b0011 << {op_addr[1], 1'b0}) : (4'b0001 << op_addr[1:0]);
    assign wdata_calc  = op_size[1] ? op_wdata : op_size[0] ? {2{op_wdata[15:0]}} : {4{op_wdata[7:0]}};
    assign rdata_shift = ld_size[1] ? mem_rdata : ld_size[0] ? (mem_rdata >> {ld_lane[1], 4'b0000}) : (mem_rdata >> {ld_lane, 3'b000});
    assign ext_calc    = ld_size[1] ? 3'b000 : ld_size[0] ? (ld_unsigned ? 3'b100 : 3'b011) : (ld_unsigned ? 3'b010 : 3'b001);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [15:0] cnt;
    logic        timed_out;
    assign timeout = state == BUSY && !mem_ack && cnt == 16'(TIMEOUT_CYCLES - 1);
    assign bus_err = state == DONE && timed_out;
    // count unacknowledged BUSY cycles and remember whether DONE was reached by abort
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            cnt       <= accept ? '0 : (state == BUSY && !mem_ack) ? cnt + 16'd1 : cnt;
            timed_out <= timeout;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // next state: accept an aligned op, wait for ack (or abort), then one DONE cycle
    always_comb begin
        state_next = (state == IDLE) ? (accept ? BUSY : IDLE) :
                     (state == BUSY) ? ((mem_ack || timeout) ? DONE : BUSY) : IDLE;
    end

    // handshake and pipeline-control outputs decoded from state
    always_comb begin
        stall   = !reset && (state == BUSY || (state == IDLE && op_valid && !misaligned));
        done    = state == DONE;
        mem_req = state == BUSY;
        adel    = !reset && state == IDLE && op_valid && misaligned && op_load;
        ades    = !reset && state == IDLE && op_valid && misaligned && !op_load;
    end

    // latch the op into the bus registers on accept; capture load result on ack
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_load       <= 1'b0;
            ld_unsigned   <= 1'b0;
            ld_size       <= '0;
            ld_lane       <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            rdata_aligned <= '0;
            bhext_op      <= '0;
        end else begin
            if (accept) begin
                ld_load     <= op_load;
                ld_unsigned <= op_unsigned;
                ld_size     <= op_size;
                ld_lane     <= op_addr[1:0];
                mem_we      <= !op_load;
                mem_addr    <= {op_addr[31:2], 2'b00};
                mem_be      <= be_calc;
                mem_wdata   <= wdata_calc;
            end
            if (state == BUSY && mem_ack && ld_load) begin
                rdata_aligned <= rdata_shift;
                bhext_op      <= ext_calc;
            end else if (timeout && ld_load) begin
                rdata_aligned <= '0;
                bhext_op      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0, reset = 1'b1;
    logic        op_valid = 1'b0, op_load = 1'b0, op_unsigned = 1'b0;
    logic [1:0]  op_size = 2'b00;
    logic [31:0] op_addr = '0, op_wdata = '0;
    logic        stall, done, adel, ades, bus_err, mem_req, mem_we;
    logic [31:0] rdata_aligned, mem_addr, mem_wdata;
    logic [2:0]  bhext_op;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    int errors = 0, checks = 0;
    logic [31:0] last_rd = '0;
    logic [2:0]  last_ext = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  ext;
        logic        berr;
        int          kk;
    } exp_t;
    exp_t sb[$];

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_load(op_load), .op_size(op_size),
        .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall),
        .done(done), .adel(adel), .ades(ades), .rdata_aligned(rdata_aligned), .bhext_op(bhext_op),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // k = request cycle carrying the ack (1 = first); k = 0 never acks
    task automatic do_op(input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int k);
        exp_t e, f;
        int sh, stalls, reqs;
        bit got;
        e.we   = !ld;
        e.addr = {addr[31:2], 2'b00};
        if (sz == 2'b00) begin
            e.be = 4'b0001 << addr[1:0]; e.wd = {4{wdata[7:0]}}; sh = 8 * addr[1:0]; e.ext = uns ? 3'd2 : 3'd1;
        end else if (sz == 2'b01) begin
            e.be = addr[1] ? 4'b1100 : 4'b0011; e.wd = {2{wdata[15:0]}}; sh = addr[1] ? 16 : 0; e.ext = uns ? 3'd4 : 3'd3;
        end else begin
            e.be = 4'hF; e.wd = wdata; sh = 0; e.ext = 3'd0;
        end
        if (ld) begin
            e.rd = (k == 0) ? 32'h0 : rdata >> sh;
            if (k == 0) e.ext = 3'd0;
            last_rd = e.rd; last_ext = e.ext;
        end else begin
            e.rd = last_rd; e.ext = last_ext;
        end
        e.berr = (k == 0);
        e.kk   = (k == 0) ? TO : k;
        sb.push_back(e);
        op_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns; op_addr = addr; op_wdata = wdata;
        stalls = 0; reqs = 0; got = 0;
        for (int cyc = 0; cyc < 80 && !got; cyc++) begin
            @(negedge clk);
            stalls += int'(stall);
            mem_ack = 1'b0;
            mem_rdata = ~rdata;
            if (cyc == 1) op_valid = 1'b0;
            if (mem_req && sb.size() != 0) begin
                reqs++;
                chk("req_we", 32'(mem_we), 32'(sb[0].we));
                chk("req_addr", mem_addr, sb[0].addr);
                chk("req_be", 32'(mem_be), 32'(sb[0].be));
                if (sb[0].we) chk("req_wdata", mem_wdata, sb[0].wd);
                if (k != 0 && reqs == k) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (done) begin
                got = 1;
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
                f = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(f.kk + 1));
                chk("stall_cycles", 32'(stalls), 32'(f.kk + 1));
                chk("req_cycles", 32'(reqs), 32'(f.kk));
                chk("rdata_aligned", rdata_aligned, f.rd);
                chk("bhext_op", 32'(bhext_op), 32'(f.ext));
                chk("bus_err", 32'(bus_err), 32'(f.berr));
            end
        end
        if (!got) chk("done_seen", 32'(got), 32'd1);
        mem_ack = 1'b0;
        op_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata_aligned, 32'd0);
        chk({tag, "_ext"}, 32'(bhext_op), 32'd0);
        chk({tag, "_buserr"}, 32'(bus_err), 32'd0);
        chk({tag, "_adel"}, 32'(adel), 32'd0);
        chk({tag, "_ades"}, 32'(ades), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        do_op(1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 4);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 1);
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_3101, 32'h1234_565A, 32'h0, 2);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_3200, 32'hCAFE_F00D, 32'h0, 3);
        do_op(1'b1, 2'b11, 1'b0, 32'h0000_3304, 32'h0, 32'h8765_4321, 1);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_3400, 32'h0, 32'h1111_8001, 2);
        do_op(1'b1, 2'b00, 1'b1, 32'h0000_3501, 32'h0, 32'h00C3_9A00, 1);
        // misaligned load then store: exception only, no bus cycle
        op_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; op_addr = 32'h0000_4001;
        @(negedge clk);
        chk("lw_adel", 32'(adel), 32'd1);
        chk("lw_ades", 32'(ades), 32'd0);
        chk("lw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        op_load = 1'b0; op_size = 2'b01; op_addr = 32'h0000_4003;
        @(negedge clk);
        chk("lw_noreq", 32'(mem_req), 32'd0);
        chk("sh_ades", 32'(ades), 32'd1);
        chk("sh_adel", 32'(adel), 32'd0);
        chk("sh_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("sh_noreq", 32'(mem_req), 32'd0);
        chk("sh_nodone", 32'(done), 32'd0);
        @(posedge clk); #1;
        // reset in the middle of a BUSY wait; late ack must be ignored
        op_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; op_addr = 32'h0000_6000;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        last_rd = '0; last_ext = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_done", 32'(done), 32'd0);
            chk("late_ack_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_7002, 32'h0, 32'h00F0_0000, 1);
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_7100, 32'h0, 32'h0BAD_CAFE, TO);
`ifdef MEM_ACCESS_TIMEOUT_EN
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_7200, 32'h0, 32'h0, 0);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_7300, 32'h1357_9BDF, 32'h0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto a multi-cycle data-memory port with a req/ack handshake.
- Stalls the pipeline until each transaction completes.
- Generates byte enables and store-data replication, and flags misaligned accesses.
- For loads, outputs the lane-shifted read data plus the 3-bit byte/halfword extend opcode that drives the existing extender feeding WB.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUSY without mem_ack before abort. Used only with the optional feature; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  MEM stage holds a load/store this cycle
- op_load  in  1  1=load, 0=store
- op_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- op_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores and words
- op_addr  in  32  effective byte address
- op_wdata  in  32  store data, right-justified
- stall  out  1  freeze IF..MEM stages
- done  out  1  one-cycle pulse when the transaction completes
- adel  out  1  misaligned-load exception, combinational
- ades  out  1  misaligned-store exception, combinational
- rdata_aligned  out  32  load data shifted so the addressed lane sits at bit 0
- bhext_op  out  3  extender opcode: 001 sign byte, 010 zero byte, 011 sign half, 100 zero half, 000 word
- bus_err  out  1  one-cycle pulse on timeout abort; tied 0 without the feature
- mem_req  out  1  request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  {op_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset: state=IDLE. All outputs 0. Latched op cleared. Counter cleared.
- Reset mid-transaction: IDLE next edge and mem_req drops. Any late ack is ignored.
- Little-endian: byte at addr[1:0]=0 occupies bits 7:0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE with op_valid, asserts adel (load) or ades (store) combinationally.
  - stall=0, no memory access, state stays IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - op_valid and aligned: stall=1 combinationally; latch op/addr/data; go to BUSY.
  - Next cycle: mem_req=1; mem_we=!op_load; mem_addr, mem_be and mem_wdata registered from the latch.
- BUSY:
  - stall=1; mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: capture load result; go to DONE.
- DONE:
  - done=1, stall=0, mem_req=0; go to IDLE.
  - A new op is accepted at the earliest in the following IDLE cycle.
- Latency: accept at T, mem_req at T+1, ack at T+k (k>=1), done at T+k+1. Minimum stall is 2 cycles.
- mem_be:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
  - Same values driven for loads.
- mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load capture on ack:
  - rdata_aligned = mem_rdata >> (8*addr[1:0]) for byte, >> (16*addr[1]) for half, unshifted for word.
  - bhext_op set from size/op_unsigned.
  - Both registered and held until the next load completes; stores leave them unchanged.
- mem_ack outside BUSY is ignored.
- op_valid dropping while BUSY (flush) does not abort the bus cycle. The transaction completes and done still pulses.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to DONE, pulse done and bus_err together.
  - A load leaves rdata_aligned=0 and bhext_op=000.
  - Ack arriving on the timeout cycle wins: normal completion, no bus_err.
- Undefined: no counter; BUSY waits indefinitely; bus_err constant 0.

Test Plan:
- Reset asserted for 2 cycles mid-BUSY -> mem_req=0 and stall=0 on the next edge; all outputs 0; a later ack produces no done.
- LB, addr 0x1003, signed, mem_rdata 0x80FF_1234, ack at first req cycle -> mem_be=1000, rdata_aligned[7:0]=0x80, bhext_op=001, done 2 cycles after accept.
- LHU, addr 0x2002, mem_rdata 0xBEEF_0000, ack after 3 wait cycles -> mem_be=1100, rdata_aligned[15:0]=0xBEEF, bhext_op=100, stall high 5 cycles.
- SH, addr 0x3002, wdata 0x0000_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x3000.
- LW at 0x4001 and SH at 0x4003 -> adel / ades pulse respectively, mem_req never asserted, stall=0.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req falls after 4 BUSY cycles, done and bus_err pulse together; a repeat test with ack on the 4th cycle gives no bus_err.
